// File: rtl/pkt_store_mem.sv
// Receive-path packet store: circular byte RAM plus a queue of committed frame lengths.
// Frames are committed or rewound at end-of-frame; the oldest packet streams out over valid/ready.
module pkt_store_mem #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 11,
  parameter int LQ_AW      = 2,
  parameter int MAX_LEN    = 1518,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  iclk,
  input  logic                  i_rst_n,
  input  logic                  i_dv,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic                  i_crc_ok,
  input  logic                  i_error,
  input  logic                  i_rd_req,
  input  logic                  i_rd_ready,
  output logic                  o_pkt_avail,
  output logic [LEN_W-1:0]      o_pkt_len,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  output logic [LQ_AW:0]        o_pkt_cnt,
  output logic [ADDR_W:0]       o_free,
  output logic                  o_drop,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LQ_DEPTH = 1 << LQ_AW;
  localparam int CW       = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [LEN_W-1:0]      r_lq  [LQ_DEPTH];

  wstate_t               r_wstate, w_wstate_next;
  rstate_t               r_rstate, w_rstate_next;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [CW-1:0]         r_len;
  logic [ADDR_W:0]       r_free;
  logic [LQ_AW:0]        r_pkt_cnt;
  logic [LQ_AW-1:0]      r_lq_wr;
  logic [LQ_AW-1:0]      r_lq_rd;
  logic [LEN_W-1:0]      r_rem;
  logic                  r_rd_valid;
  logic [DATA_W-1:0]     r_ram_q;
  logic                  r_drop;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_we;
  logic [ADDR_W-1:0]     w_waddr;
  logic [CW-1:0]         w_len_next;
  logic                  w_commit;
  logic [LEN_W-1:0]      w_commit_len;
  logic                  w_drop_abort;
  logic                  w_drop_end;
  logic                  w_can_start;
  logic [CW-1:0]         w_free_cw;
  logic [CW-1:0]         w_max_cw;
  logic                  w_re;
  logic [ADDR_W-1:0]     w_raddr;
  logic                  w_release;
  logic                  w_pkt_avail;
  logic [LEN_W-1:0]      w_head_len;
  logic [ADDR_W:0]       w_free_sub;
  logic [ADDR_W:0]       w_free_add;
  logic [DROP_CNT_W:0]   w_drop_sum;

  assign w_pkt_avail = (r_pkt_cnt != '0);
  assign w_head_len  = r_lq[r_lq_rd];
  assign w_free_cw   = CW'(r_free);
  assign w_max_cw    = CW'(MAX_LEN);
  assign w_can_start = (r_pkt_cnt != (LQ_AW+1)'(LQ_DEPTH)) && (r_free != '0);

  // Write side: bytes land at r_wr_ptr+len; r_wr_ptr only moves on commit, so a drop is a rewind.
  always_comb begin
    w_wstate_next = r_wstate;
    w_we          = 1'b0;
    w_waddr       = r_wr_ptr;
    w_len_next    = r_len;
    w_commit      = 1'b0;
    w_commit_len  = '0;
    w_drop_abort  = 1'b0;
    w_drop_end    = 1'b0;
    case (r_wstate)
      W_IDLE, W_RECV: begin
        if (i_dv && i_sof) begin
          w_drop_abort = (r_wstate == W_RECV);
          if (!w_can_start) begin
            if (i_eof) begin
              w_drop_end    = 1'b1;
              w_wstate_next = W_IDLE;
            end else begin
              w_wstate_next = W_DROP;
            end
          end else begin
            w_we       = 1'b1;
            w_waddr    = r_wr_ptr;
            w_len_next = CW'(1);
            if (i_eof) begin
              if (i_crc_ok && !i_error) begin
                w_commit     = 1'b1;
                w_commit_len = LEN_W'(1);
              end else begin
                w_drop_end = 1'b1;
              end
              w_wstate_next = W_IDLE;
            end else if (i_error) begin
              w_wstate_next = W_DROP;
            end else begin
              w_wstate_next = W_RECV;
            end
          end
        end else if (r_wstate == W_RECV && (i_error || i_dv)) begin
          // A byte beyond free space or MAX_LEN, or any error, poisons the frame.
          if (i_error || r_len == w_free_cw || r_len == w_max_cw) begin
            if (i_dv && i_eof) begin
              w_drop_end    = 1'b1;
              w_wstate_next = W_IDLE;
            end else begin
              w_wstate_next = W_DROP;
            end
          end else begin
            w_we       = 1'b1;
            w_waddr    = r_wr_ptr + r_len[ADDR_W-1:0];
            w_len_next = r_len + CW'(1);
            if (i_eof) begin
              if (i_crc_ok) begin
                w_commit     = 1'b1;
                w_commit_len = w_len_next[LEN_W-1:0];
              end else begin
                w_drop_end = 1'b1;
              end
              w_wstate_next = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (i_dv && i_eof) begin
          w_drop_end    = 1'b1;
          w_wstate_next = W_IDLE;
        end
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Read side: one RAM read is always in flight ahead of the sink, giving bubble-free streaming.
  always_comb begin
    w_rstate_next = r_rstate;
    w_re          = 1'b0;
    w_raddr       = r_rd_addr;
    w_release     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (i_rd_req && w_pkt_avail) begin
          w_re          = 1'b1;
          w_raddr       = r_rd_ptr;
          w_rstate_next = R_FETCH;
        end
      end
      R_FETCH: w_rstate_next = R_STREAM;
      R_STREAM: begin
        if (i_rd_ready) begin
          if (r_rem == LEN_W'(1)) begin
            w_release     = 1'b1;
            w_rstate_next = R_IDLE;
          end else begin
            w_re    = 1'b1;
            w_raddr = r_rd_addr;
          end
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  assign w_free_sub = w_commit  ? (ADDR_W+1)'(w_commit_len) : '0;
  assign w_free_add = w_release ? (ADDR_W+1)'(w_head_len)   : '0;
  assign w_drop_sum = {1'b0, r_drop_cnt} + (DROP_CNT_W+1)'(w_drop_abort)
                    + (DROP_CNT_W+1)'(w_drop_end);

  always_ff @(posedge iclk) begin
    if (w_we) r_mem[w_waddr] <= i_data;
  end

  always_ff @(posedge iclk) begin
    if (w_re) r_ram_q <= r_mem[w_raddr];
  end

  always_ff @(posedge iclk) begin
    if (w_commit) r_lq[r_lq_wr] <= w_commit_len;
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_addr  <= '0;
      r_len      <= '0;
      r_free     <= (ADDR_W+1)'(DEPTH);
      r_pkt_cnt  <= '0;
      r_lq_wr    <= '0;
      r_lq_rd    <= '0;
      r_rem      <= '0;
      r_rd_valid <= 1'b0;
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
      r_len    <= w_len_next;
      r_drop   <= w_drop_abort | w_drop_end;
      r_free   <= r_free - w_free_sub + w_free_add;
      if (w_drop_sum[DROP_CNT_W]) r_drop_cnt <= '1;
      else                        r_drop_cnt <= w_drop_sum[DROP_CNT_W-1:0];
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(w_commit_len);
        r_lq_wr  <= r_lq_wr + LQ_AW'(1);
      end
      if (w_commit && !w_release)      r_pkt_cnt <= r_pkt_cnt + (LQ_AW+1)'(1);
      else if (!w_commit && w_release) r_pkt_cnt <= r_pkt_cnt - (LQ_AW+1)'(1);
      case (r_rstate)
        R_IDLE: begin
          if (i_rd_req && w_pkt_avail) begin
            r_rem     <= w_head_len;
            r_rd_addr <= r_rd_ptr + ADDR_W'(1);
          end
        end
        R_FETCH: r_rd_valid <= 1'b1;
        R_STREAM: begin
          if (i_rd_ready) begin
            if (w_release) begin
              // r_rd_addr has advanced exactly len bytes past r_rd_ptr by now.
              r_rd_valid <= 1'b0;
              r_rd_ptr   <= r_rd_addr;
              r_lq_rd    <= r_lq_rd + LQ_AW'(1);
            end else begin
              r_rem     <= r_rem - LEN_W'(1);
              r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
          end
        end
        default: r_rd_valid <= 1'b0;
      endcase
    end
  end

  assign o_pkt_avail = w_pkt_avail;
  assign o_pkt_len   = w_pkt_avail ? w_head_len : '0;
  assign o_rd_data   = r_rd_valid ? r_ram_q : '0;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_last   = r_rd_valid && (r_rem == LEN_W'(1));
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_free      = r_free;
  assign o_drop      = r_drop;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
